// File: rtl/queen_position_stack_if.sv
// Bus between the solver controller (master) and the queen position stack (slave).
interface queen_position_stack_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 3
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    read_index;
    logic [WIDTH-1:0] read_data;
    logic [WIDTH-1:0] top;
    logic [CW-1:0]    count;
    logic             stack_ready;
    logic             underflow;
    logic             overflow;
    logic             empty;
    logic             full;

    modport master (
        output clear, push, pop, data_in, read_index,
        input  read_data, top, count, stack_ready, underflow, overflow, empty, full
    );

    modport slave (
        input  clear, push, pop, data_in, read_index,
        output read_data, top, count, stack_ready, underflow, overflow, empty, full
    );
endinterface

// File: rtl/queen_position_stack.sv
// Column-position stack for the 8-Queen solver: one entry per placed row,
// one-cycle busy handshake, sticky error flags, replace-top and random-access read.
module queen_position_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    queen_position_stack_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        REMOVE  = 2'd2,
        REPLACE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_wr_data;
    logic             r_underflow;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [CW-1:0]    w_count_nxt;
    logic             w_set_ovf;
    logic             w_set_unf;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Next state and the single commit action of each busy state.
    always_comb begin
        w_next_state = IDLE;
        w_we         = 1'b0;
        w_waddr      = '0;
        w_count_nxt  = r_count;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.push && !bus.pop) begin
                    w_next_state = WRITE;
                end else if (bus.pop && !bus.push) begin
                    w_next_state = REMOVE;
                end else if (bus.push && bus.pop) begin
                    w_next_state = REPLACE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WRITE: begin
                if (!w_full) begin
                    w_we        = 1'b1;
                    w_waddr     = AW'(r_count);
                    w_count_nxt = r_count + CW'(1);
                end else begin
                    w_set_ovf = 1'b1;
                end
            end
            REMOVE: begin
                if (!w_empty) begin
                    w_count_nxt = r_count - CW'(1);
                end else begin
                    w_set_unf = 1'b1;
                end
            end
            REPLACE: begin
                // Empty stack: a replace degenerates to a plain push into row 0.
                w_we = 1'b1;
                if (!w_empty) begin
                    w_waddr = AW'(r_count - CW'(1));
                end else begin
                    w_waddr     = '0;
                    w_count_nxt = CW'(1);
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, storage and flags; clear resets pointer/flags but keeps memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_wr_data   <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.clear) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_count_nxt;
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end
            if (w_set_unf) begin
                r_underflow <= 1'b1;
            end
            if (w_we) begin
                r_mem[w_waddr] <= r_wr_data;
            end
            if (r_state == IDLE && bus.push) begin
                r_wr_data <= bus.data_in;
            end
        end
    end

    assign bus.count       = r_count;
    assign bus.stack_ready = (r_state == IDLE);
    assign bus.underflow   = r_underflow;
    assign bus.overflow    = r_overflow;
    assign bus.empty       = w_empty;
    assign bus.full        = w_full;
    assign bus.read_data   = (CW'(bus.read_index) < r_count) ? r_mem[bus.read_index] : '0;
    assign bus.top         = w_empty ? '0 : r_mem[AW'(r_count - CW'(1))];
endmodule

// File: doc/queen_position_stack.md
# queen_position_stack

Hardware stack holding the column position of each placed queen, one entry per board row, for the 8-Queen solver datapath. It sits directly downstream of the solver controller:
- The controller issues single-cycle `push`/`pop` strobes, waits on `stack_ready`, and reads `underflow`.
- The safety checker and the output transmitter read earlier placements through a random-access read port.
- The block provides a one-cycle busy handshake, sticky error flags and replace-top.

## Interface
- `DEPTH`, 8, maximum number of stored entries (board rows).
- `WIDTH`, 3, bits per entry (column index).
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state.
- `clear`  input  1  synchronous clear of the stack pointer and flags.
- `push`  input  1  push strobe, sampled only while `stack_ready`=1.
- `pop`  input  1  pop strobe, sampled only while `stack_ready`=1.
- `data_in`  input  WIDTH  value to push.
- `read_index`  input  $clog2(DEPTH)  entry to read (0 = bottom / row 0).
- `read_data`  output  WIDTH  combinational: `mem[read_index]` if `read_index` < `count`, else 0.
- `top`  output  WIDTH  combinational: `mem[count-1]`, or 0 when empty.
- `count`  output  $clog2(DEPTH+1)  number of valid entries.
- `stack_ready`  output  1  1 = idle and accepting a strobe.
- `underflow`  output  1  sticky; set by a pop on an empty stack.
- `overflow`  output  1  sticky; set by a push on a full stack.
- `empty`  output  1  `count`==0.
- `full`  output  1  `count`==DEPTH.

## Operation
- FSM states: `IDLE` (`stack_ready`=1), `WRITE`, `REMOVE`, `REPLACE`. Every busy state lasts exactly one cycle and then returns to `IDLE`.
- Decode in `IDLE`:
  - `push` & ~`pop` → `WRITE`; `data_in` is latched into `wr_data`.
  - `pop` & ~`push` → `REMOVE`.
  - `push` & `pop` → `REPLACE`; `data_in` is latched.
  - Neither strobe → stay in `IDLE`.
- Strobes asserted outside `IDLE` are ignored. They are not queued and cause no flag change.
- `WRITE`:
  - If not full: `mem[count]` ← `wr_data` and `count`+1.
  - If full: memory and `count` are unchanged and `overflow` is set.
- `REMOVE`:
  - If not empty: `count`−1. Memory contents are left intact.
  - If empty: `count` stays 0 and `underflow` is set.
- `REPLACE`:
  - If not empty: `mem[count-1]` ← `wr_data`; `count` is unchanged. This is a backtrack-and-advance in one step.
  - If empty: behaves as `WRITE`.
- The busy cycle is taken even on the error paths, so a controller waiting on `stack_ready` always proceeds.
- `clear` (synchronous) has priority over all strobes and FSM activity:
  - Next edge: `count`=0, `underflow`=0, `overflow`=0, state=`IDLE`.
  - Memory contents are retained.
- `reset` (asynchronous) acts immediately, including mid-operation; a pending write is discarded. Afterwards:
  - state=`IDLE`, `count`=0, all `mem` entries=0.
  - `underflow`=0, `overflow`=0.
- Output values immediately after reset: `stack_ready`=1, `empty`=1, `full`=0, `top`=0, `read_data`=0.
- Width rules:
  - `count` never exceeds DEPTH and never goes below 0 (no wrap).
  - The write address is `count` truncated to $clog2(DEPTH) bits, and is used only when not full.

## Timing
- Strobe sampled at edge E0 → `stack_ready`=0 during cycle E0..E1.
- The memory/`count` update commits at E1 → `stack_ready`=1, and `top`/`count`/`read_data` show the new values after E1.
- Latency is 2 edges from strobe to the next acceptable strobe. Maximum throughput is one operation per 2 cycles.
- `underflow`/`overflow` rise at the commit edge E1 and stay high until `clear` or `reset`.
- `read_data`, `top`, `empty` and `full` are purely combinational from registered state. There is no same-cycle write-through: a value being written is not visible until after the commit edge.

## Test plan
- Reset/push checks:
  - Reset, then push 3,5,0 (each waiting for `stack_ready`) → `count`=3, `top`=0.
  - `read_index`=1 → `read_data`=5; `read_index`=3 → `read_data`=0.
  - `stack_ready` is low for exactly 1 cycle per push.
- Push 8 values 0..7, then push 6 → `full`=1, `count`=8, `top`=7, `overflow`=1 at the commit edge, `stack_ready` still returns to 1.
- From empty, pop → `count`=0, `underflow`=1 one edge later. Then `clear` → `underflow`=0 next edge.
- Replace-top:
  - Stack [2,4]: push&pop with `data_in`=6 → `count`=2, `top`=6, `read_index`=0 gives 2.
  - Same strobe on an empty stack → `count`=1, `top`=6.
- Push 1 and, in the busy cycle, assert pop → pop is ignored, and `count`=1 after both cycles.
- Assert `reset` asynchronously mid-`WRITE` (between edges) → outputs go to their reset values immediately; the write never commits; `count`=0.
